// File: rtl/sensor_poll_scheduler_pkg.sv
// Shared definitions for the sensor poll scheduler.
//   - 2-bit per-sensor status codes reported in the result word
//   - controller state encoding
//   - default XOR key and the plain-text reply nibbles
//   - reply_status(): maps a reply nibble to its status code
package poll_pkg;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ALARM   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_BAD     = 2'b11;

    localparam logic [7:0] KEY_DEFAULT = 8'h37;

    localparam logic [3:0] REPLY_OK    = 4'h0;
    localparam logic [3:0] REPLY_ALARM = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_SEND,
        S_WAIT,
        S_REPORT
    } state_e;

    // Any code other than the two defined ones is a corrupted reply.
    function automatic logic [1:0] reply_status(input logic [3:0] code);
        logic [1:0] st;
        if (code == REPLY_OK) begin
            st = ST_OK;
        end else if (code == REPLY_ALARM) begin
            st = ST_ALARM;
        end else begin
            st = ST_BAD;
        end
        return st;
    endfunction

endpackage

// File: rtl/sensor_poll_scheduler_timer.sv
// link_timeout_timer: reply-wait cycle counter for the poll scheduler.
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   clear_i    in   force the count to zero (has priority over enable_i)
//   enable_i   in   advance the count by one this cycle
//   expired_o  out  count has reached TIMEOUT_CYC-1
module link_timeout_timer
    import poll_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != {CNT_W{1'b1}})) begin
            // Saturate rather than wrap so an expiry can never be skipped.
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // >= keeps the expiry sticky should the count ever run past the mark.
    assign expired_o = (count_q >= EXPIRE_AT);

endmodule

// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler: polls a mask of alarm sensors over one shared,
// XOR-keyed byte link on behalf of a CPU custom instruction.
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   command strobe, honoured only while idle
//   dataa     in   [N_SENSORS-1:0] poll mask, bit i selects sensor id i+1
//   result    out  [2i+1:2i] status of sensor i+1, [31] any ALARM, [30] any TIMEOUT
//   done      out  one-cycle pulse, result valid from this cycle
//   busy      out  command in progress
//   tx_data   out  keyed request byte
//   tx_valid  out  request valid, held stable until tx_ready
//   tx_ready  in   link accepts the request
//   rx_data   in   keyed reply byte
//   rx_valid  in   single-cycle reply strobe
module sensor_poll_scheduler
    import poll_pkg::*;
#(
    parameter int         N_SENSORS   = 4,
    parameter logic [7:0] KEY         = poll_pkg::KEY_DEFAULT,
    parameter int         TIMEOUT_CYC = 1000,
    parameter int         CNT_W       = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    state_e                 state_q, state_d;
    logic [N_SENSORS-1:0]   mask_q, mask_d;
    logic [3:0]             ptr_q, ptr_d;
    logic [3:0]             cur_q, cur_d;
    logic [31:0]            result_q, result_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;

    logic                   scan_found;
    logic [3:0]             scan_idx;
    logic                   any_alarm;
    logic                   any_timeout;
    logic [7:0]             rx_plain;
    logic [3:0]             cur_id;
    logic                   rx_match;
    logic                   tmr_clr;
    logic                   tmr_en;
    logic                   tmr_expired;

    // Mask bits above the sensor count are don't-care.
    logic                   unused_dataa;
    assign unused_dataa = ^dataa[31:N_SENSORS];

    // Lowest selected sensor at or above ptr, resolved in a single cycle.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(ptr_q))) begin
                scan_found = 1'b1;
                scan_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        any_alarm   = 1'b0;
        any_timeout = 1'b0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (result_q[2*i +: 2] == ST_ALARM) begin
                any_alarm = 1'b1;
            end
            if (result_q[2*i +: 2] == ST_TIMEOUT) begin
                any_timeout = 1'b1;
            end
        end
    end

    assign rx_plain = rx_data ^ KEY;
    assign cur_id   = cur_q + 4'd1;
    assign rx_match = rx_valid && (rx_plain[7:4] == cur_id);

    // The timer is held at zero while scanning or while the request is
    // stalled, and counts from the accepting handshake cycle onwards, so the
    // handshake cycle itself is tick 0 of the reply window.
    link_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (tmr_clr),
        .enable_i  (tmr_en),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        ptr_d      = ptr_q;
        cur_d      = cur_q;
        result_d   = result_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d   = dataa[N_SENSORS-1:0];
                    result_d = '0;
                    ptr_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SCAN;
                end
            end

            S_SCAN: begin
                tmr_clr = 1'b1;
                if (scan_found) begin
                    cur_d      = scan_idx;
                    tx_data_d  = {4'h0, scan_idx + 4'd1} ^ KEY;
                    tx_valid_d = 1'b1;
                    state_d    = S_SEND;
                end else begin
                    // Summary flags and done are registered together so the
                    // whole result word is valid in the done cycle.
                    result_d[31] = any_alarm;
                    result_d[30] = any_timeout;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_REPORT;
                end
            end

            S_SEND: begin
                tmr_en = 1'b1;
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_WAIT;
                end else begin
                    tmr_clr = 1'b1;
                end
            end

            S_WAIT: begin
                tmr_en = 1'b1;
                // A matching reply takes precedence over a same-cycle expiry.
                if (rx_match) begin
                    result_d[2*int'(cur_q) +: 2] = reply_status(rx_plain[3:0]);
                    ptr_d   = cur_id;
                    state_d = S_SCAN;
                end else if (tmr_expired) begin
                    result_d[2*int'(cur_q) +: 2] = ST_TIMEOUT;
                    ptr_d   = cur_id;
                    state_d = S_SCAN;
                end
            end

            S_REPORT: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            ptr_q      <= '0;
            cur_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            ptr_q      <= ptr_d;
            cur_q      <= cur_d;
            result_q   <= result_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign result   = result_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
module tb_sensor_poll_scheduler;

    localparam int T = 1000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int exp_dones = 0;

    logic [31:0] exp_res_q[$];
    logic [7:0]  exp_tx_q[$];

    sensor_poll_scheduler #(
        .N_SENSORS   (4),
        .KEY         (8'h37),
        .TIMEOUT_CYC (T),
        .CNT_W       (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dataa    (dataa),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: pops expected request bytes and results as the DUT emits them.
    initial begin
        forever begin
            @(negedge clock);
            if (done) begin
                done_cnt++;
                if (exp_res_q.size() > 0) check("result", result, exp_res_q.pop_front());
                else check("done_extra", 32'(done), 32'd0);
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx_q.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_tx_q.pop_front()));
                else check("tx_extra", 32'(tx_valid), 32'd0);
            end
        end
    end

    task automatic cmd(input logic [31:0] mask, input logic [31:0] exp_res);
        exp_res_q.push_back(exp_res);
        exp_dones++;
        @(posedge clock); #1;
        start = 1'b1;
        dataa = mask;
        start_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0;
        dataa = '0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_tx();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (tx_valid && tx_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("tx_wait", 32'(tx_valid), 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clock); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock); #1;
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic wait_done(output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int i = 0; i < 2 * T; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                lat = cyc - start_cyc;
                break;
            end
        end
        if (!seen) check("done_wait", 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_result", result, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // 1: single sensor, OK reply
        exp_tx_q.push_back(8'h36);
        cmd(32'h1, 32'h0000_0000);
        wait_tx();
        send_rx(8'h27);
        wait_done(lat);
        @(negedge clock);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // 2: sensors 2 (ALARM) and 4 (OK)
        exp_tx_q.push_back(8'h35);
        exp_tx_q.push_back(8'h33);
        cmd(32'hA, 32'h8000_0004);
        wait_tx();
        send_rx(8'h2F ^ 8'h37);
        wait_tx();
        send_rx(8'h40 ^ 8'h37);
        wait_done(lat);

        // 3: sensor 3, no reply -> TIMEOUT with exact latency
        exp_tx_q.push_back(8'h34);
        cmd(32'h4, 32'h4000_0020);
        wait_done(lat);
        check("t3_latency", 32'(lat), 32'(T + 3));

        // 4: wrong-id byte ignored, then corrupted code -> BAD
        exp_tx_q.push_back(8'h36);
        cmd(32'h1, 32'h0000_0003);
        wait_tx();
        send_rx(8'h20 ^ 8'h37);
        send_rx(8'h13 ^ 8'h37);
        wait_done(lat);

        // 5: empty mask, then start while busy is ignored
        cmd(32'h0, 32'h0000_0000);
        wait_done(lat);
        check("t5_latency", 32'(lat), 32'd2);
        exp_tx_q.push_back(8'h36);
        cmd(32'h1, 32'h0000_0000);
        wait_tx();
        @(posedge clock); #1;
        start = 1'b1;
        dataa = 32'hF;
        @(posedge clock); #1;
        start = 1'b0;
        dataa = '0;
        send_rx(8'h27);
        wait_done(lat);
        repeat (10) @(negedge clock);
        check("t5_done_count", 32'(done_cnt), 32'(exp_dones));

        // 6: reset during WAIT aborts; a new command then runs normally
        exp_tx_q.push_back(8'h36);
        exp_res_q.push_back(32'h0);  // aborted command yields no result entry
        void'(exp_res_q.pop_back());
        @(posedge clock); #1;
        start = 1'b1;
        dataa = 32'h1;
        @(posedge clock); #1;
        start = 1'b0;
        dataa = '0;
        wait_tx();
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("t6_tx_valid", 32'(tx_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_result", result, 32'd0);
        check("t6_tx_data", 32'(tx_data), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("t6_no_done", 32'(done_cnt), 32'(exp_dones));
        exp_tx_q.push_back(8'h36);
        exp_tx_q.push_back(8'h35);
        cmd(32'h3, 32'h8000_0004);
        wait_tx();
        send_rx(8'h10 ^ 8'h37);
        wait_tx();
        send_rx(8'h2F ^ 8'h37);
        wait_done(lat);

        repeat (4) @(negedge clock);
        check("final_done_count", 32'(done_cnt), 32'(exp_dones));
        check("sb_tx_empty", 32'(exp_tx_q.size()), 32'd0);
        check("sb_res_empty", 32'(exp_res_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
